// File: rtl/mem_bus_arbiter.sv
// Purpose: arbitrates the instruction-fetch and data load/store ports onto one
//          req/ack memory bus; data accesses have fixed priority over fetches.
// Latency: request seen in cycle 0 -> bus_req_o in cycle 1; ack in cycle k -> result in cycle k+1.
// Backpressure: stallreq_o (combinational) holds the pipeline until every active access completes;
//               bus_* outputs stay stable from request until bus_ack_i.
// Ports: clk/rst (sync, active-high); inst_* fetch port; data_* load/store port; flush_i from ctrl;
//        stallreq_o to ctrl; bus_* registered request side, bus_rdata_i/bus_ack_i slave response.
module mem_bus_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                inst_ce_i,
    input  logic [ADDR_W-1:0]   inst_addr_i,
    output logic [DATA_W-1:0]   inst_data_o,
    input  logic                data_ce_i,
    input  logic                data_we_i,
    input  logic [ADDR_W-1:0]   data_addr_i,
    input  logic [DATA_W/8-1:0] data_sel_i,
    input  logic [DATA_W-1:0]   data_wdata_i,
    output logic [DATA_W-1:0]   data_rdata_o,
    input  logic                flush_i,
    output logic                stallreq_o,
    output logic                bus_req_o,
    output logic                bus_we_o,
    output logic [ADDR_W-1:0]   bus_addr_o,
    output logic [DATA_W/8-1:0] bus_sel_o,
    output logic [DATA_W-1:0]   bus_wdata_o,
    input  logic [DATA_W-1:0]   bus_rdata_i,
    input  logic                bus_ack_i
);

    localparam int SEL_W = DATA_W / 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_INST = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                inst_done_q, inst_done_d;
    logic                data_done_q, data_done_d;
    logic                discard_q, discard_d;
    logic                bus_req_q, bus_req_d;
    logic                bus_we_q, bus_we_d;
    logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
    logic [SEL_W-1:0]    bus_sel_q, bus_sel_d;
    logic [DATA_W-1:0]   bus_wdata_q, bus_wdata_d;
    logic [DATA_W-1:0]   inst_data_q, inst_data_d;
    logic [DATA_W-1:0]   data_rdata_q, data_rdata_d;

    logic inst_pend;
    logic data_pend;

    assign inst_pend  = inst_ce_i & ~inst_done_q;
    assign data_pend  = data_ce_i & ~data_done_q;
    assign stallreq_o = inst_pend | data_pend;

    always_comb begin
        state_d      = state_q;
        inst_done_d  = inst_done_q;
        data_done_d  = data_done_q;
        discard_d    = discard_q;
        bus_req_d    = bus_req_q;
        bus_we_d     = bus_we_q;
        bus_addr_d   = bus_addr_q;
        bus_sel_d    = bus_sel_q;
        bus_wdata_d  = bus_wdata_q;
        inst_data_d  = inst_data_q;
        data_rdata_d = data_rdata_q;

        // Pipeline advances (no stall) or is flushed: completion state belongs
        // to the old cycle. A same-edge ack below may set a flag again.
        if (!stallreq_o || flush_i) begin
            inst_done_d = 1'b0;
            data_done_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (data_pend) begin
                    state_d     = S_DATA;
                    bus_req_d   = 1'b1;
                    bus_we_d    = data_we_i;
                    bus_addr_d  = data_addr_i;
                    bus_sel_d   = data_sel_i;
                    bus_wdata_d = data_wdata_i;
                end else if (inst_pend) begin
                    state_d    = S_INST;
                    bus_req_d  = 1'b1;
                    bus_we_d   = 1'b0;
                    bus_addr_d = inst_addr_i;
                    bus_sel_d  = '1;
                end else begin
                    bus_req_d = 1'b0;
                end
            end
            S_DATA, S_INST: begin
                if (bus_ack_i) begin
                    state_d   = S_IDLE;
                    bus_req_d = 1'b0;
                    discard_d = 1'b0;
                    // A flush on the ack edge drops the result just like an earlier flush.
                    if (!discard_q && !flush_i) begin
                        if (state_q == S_DATA) begin
                            data_done_d = 1'b1;
                            if (!bus_we_q) begin
                                data_rdata_d = bus_rdata_i;
                            end
                        end else begin
                            inst_done_d = 1'b1;
                            inst_data_d = bus_rdata_i;
                        end
                    end
                end else if (flush_i) begin
                    // Transfer cannot be aborted on the bus; remember to drop its result.
                    discard_d = 1'b1;
                end
            end
            default: begin
                state_d   = S_IDLE;
                bus_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            inst_done_q  <= 1'b0;
            data_done_q  <= 1'b0;
            discard_q    <= 1'b0;
            bus_req_q    <= 1'b0;
            bus_we_q     <= 1'b0;
            bus_addr_q   <= '0;
            bus_sel_q    <= '0;
            bus_wdata_q  <= '0;
            inst_data_q  <= '0;
            data_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            inst_done_q  <= inst_done_d;
            data_done_q  <= data_done_d;
            discard_q    <= discard_d;
            bus_req_q    <= bus_req_d;
            bus_we_q     <= bus_we_d;
            bus_addr_q   <= bus_addr_d;
            bus_sel_q    <= bus_sel_d;
            bus_wdata_q  <= bus_wdata_d;
            inst_data_q  <= inst_data_d;
            data_rdata_q <= data_rdata_d;
        end
    end

    assign bus_req_o    = bus_req_q;
    assign bus_we_o     = bus_we_q;
    assign bus_addr_o   = bus_addr_q;
    assign bus_sel_o    = bus_sel_q;
    assign bus_wdata_o  = bus_wdata_q;
    assign inst_data_o  = inst_data_q;
    assign data_rdata_o = data_rdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Purpose: self-checking bench for mem_bus_arbiter against a transaction-level reference model.
// Latency: one model step per clock; outputs sampled 1 time unit after each edge.
// Backpressure: a bench-side slave acks after a programmable number of cycles.
module tb_mem_bus_arbiter;

    logic        clk;
    logic        rst;
    logic        inst_ce_i;
    logic [31:0] inst_addr_i;
    logic [31:0] inst_data_o;
    logic        data_ce_i;
    logic        data_we_i;
    logic [31:0] data_addr_i;
    logic [3:0]  data_sel_i;
    logic [31:0] data_wdata_i;
    logic [31:0] data_rdata_o;
    logic        flush_i;
    logic        stallreq_o;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [3:0]  bus_sel_o;
    logic [31:0] bus_wdata_o;
    logic [31:0] bus_rdata_i;
    logic        bus_ack_i;

    mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .inst_ce_i   (inst_ce_i),
        .inst_addr_i (inst_addr_i),
        .inst_data_o (inst_data_o),
        .data_ce_i   (data_ce_i),
        .data_we_i   (data_we_i),
        .data_addr_i (data_addr_i),
        .data_sel_i  (data_sel_i),
        .data_wdata_i(data_wdata_i),
        .data_rdata_o(data_rdata_o),
        .flush_i     (flush_i),
        .stallreq_o  (stallreq_o),
        .bus_req_o   (bus_req_o),
        .bus_we_o    (bus_we_o),
        .bus_addr_o  (bus_addr_o),
        .bus_sel_o   (bus_sel_o),
        .bus_wdata_o (bus_wdata_o),
        .bus_rdata_i (bus_rdata_i),
        .bus_ack_i   (bus_ack_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: one outstanding bus transfer record plus completion flags.
    bit        m_busy, m_is_data, m_we, m_drop;
    bit [31:0] m_addr, m_wdata;
    bit [3:0]  m_sel;
    bit        m_idone, m_ddone;
    bit [31:0] m_inst, m_drd;

    // Bench-side slave.
    bit        slave_en;
    int        slave_lat;
    int        slave_cnt;
    int        slave_mode;   // 0 fixed value, 1 random, 2 derived from address
    bit [31:0] slave_rdata;
    bit        last_stall;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_update();
        bit pi, pd, ni, nd;
        if (rst) begin
            m_busy = 0; m_drop = 0; m_idone = 0; m_ddone = 0;
            m_inst = 0; m_drd = 0; m_we = 0; m_addr = 0; m_sel = 0; m_wdata = 0;
        end else begin
            pi = inst_ce_i && !m_idone;
            pd = data_ce_i && !m_ddone;
            ni = m_idone;
            nd = m_ddone;
            if (!(pi || pd) || flush_i) begin
                ni = 0;
                nd = 0;
            end
            if (m_busy) begin
                if (bus_ack_i) begin
                    if (!m_drop && !flush_i) begin
                        if (m_is_data) begin
                            nd = 1;
                            if (!m_we) m_drd = bus_rdata_i;
                        end else begin
                            ni = 1;
                            m_inst = bus_rdata_i;
                        end
                    end
                    m_busy = 0;
                    m_drop = 0;
                end else if (flush_i) begin
                    m_drop = 1;
                end
            end else if (pd) begin
                m_busy = 1; m_is_data = 1; m_we = data_we_i;
                m_addr = data_addr_i; m_sel = data_sel_i; m_wdata = data_wdata_i;
            end else if (pi) begin
                m_busy = 1; m_is_data = 0; m_we = 0;
                m_addr = inst_addr_i; m_sel = 4'hF;
            end
            m_idone = ni;
            m_ddone = nd;
        end
    endtask

    // One clock: entered just after a falling edge with inputs applied.
    task automatic cycle();
        bit exp_stall;
        if (slave_en) begin
            if (bus_req_o) begin
                if (slave_cnt >= slave_lat) begin
                    bus_ack_i = 1'b1;
                    case (slave_mode)
                        0:       bus_rdata_i = slave_rdata;
                        1:       bus_rdata_i = $urandom;
                        default: bus_rdata_i = bus_addr_o ^ 32'hC0DE_0000;
                    endcase
                    slave_cnt = 0;
                end else begin
                    bus_ack_i = 1'b0;
                    slave_cnt++;
                end
            end else begin
                bus_ack_i = 1'b0;
                slave_cnt = 0;
            end
        end
        #1;
        exp_stall = (inst_ce_i && !m_idone) || (data_ce_i && !m_ddone);
        chk("stallreq", stallreq_o, exp_stall);
        last_stall = stallreq_o;
        model_update();
        @(posedge clk);
        #1;
        chk("bus_req", bus_req_o, m_busy);
        if (m_busy) begin
            chk("bus_addr", bus_addr_o, m_addr);
            chk("bus_we", bus_we_o, m_we);
            chk("bus_sel", bus_sel_o, m_sel);
            if (m_we) chk("bus_wdata", bus_wdata_o, m_wdata);
        end
        chk("inst_data", inst_data_o, m_inst);
        chk("data_rdata", data_rdata_o, m_drd);
        @(negedge clk);
    endtask

    // Runs cycles until stallreq_o is seen low; returns the number of stalled cycles.
    task automatic run_access(input string tag, input int exp_stall_cycles);
        int  cnt;
        bit  released;
        cnt = 0;
        released = 0;
        for (int i = 0; i < 60; i++) begin
            cycle();
            if (!last_stall) begin
                released = 1;
                break;
            end
            cnt++;
        end
        chk({tag, "_released"}, released, 1'b1);
        chk({tag, "_stall_cycles"}, cnt, exp_stall_cycles);
    endtask

    task automatic idle_inputs();
        inst_ce_i = 0; data_ce_i = 0; data_we_i = 0; flush_i = 0;
    endtask

    initial begin
        rst = 1; idle_inputs();
        inst_addr_i = 0; data_addr_i = 0; data_sel_i = 0; data_wdata_i = 0;
        bus_rdata_i = 0; bus_ack_i = 0;
        slave_en = 1; slave_lat = 0; slave_cnt = 0; slave_mode = 0; slave_rdata = 0;
        m_busy = 0; m_is_data = 0; m_drop = 0; m_idone = 0; m_ddone = 0;
        m_we = 0; m_addr = 0; m_sel = 0; m_wdata = 0; m_inst = 0; m_drd = 0;
        @(negedge clk);
        cycle();
        cycle();
        chk("rst_bus_req", bus_req_o, 1'b0);
        chk("rst_bus_addr", bus_addr_o, 32'h0);
        chk("rst_bus_sel", bus_sel_o, 4'h0);
        chk("rst_inst_data", inst_data_o, 32'h0);
        rst = 0;
        cycle();

        // Fetch-only, ack one cycle after the request appears.
        inst_ce_i = 1; inst_addr_i = 32'h0000_0010;
        slave_mode = 0; slave_rdata = 32'h3401_1234; slave_lat = 1;
        run_access("fetch_only", 3);
        chk("fetch_only_data", inst_data_o, 32'h3401_1234);
        idle_inputs();
        cycle();

        // Load and fetch in the same cycle, zero-wait slave.
        inst_ce_i = 1; inst_addr_i = 32'h14;
        data_ce_i = 1; data_we_i = 0; data_addr_i = 32'h80; data_sel_i = 4'b0011;
        slave_mode = 2; slave_lat = 0;
        run_access("load_fetch", 4);
        chk("load_fetch_drd", data_rdata_o, 32'hC0DE_0080);
        chk("load_fetch_inst", inst_data_o, 32'hC0DE_0014);
        idle_inputs();
        cycle();

        // Store with a slow slave.
        data_ce_i = 1; data_we_i = 1; data_addr_i = 32'h100;
        data_wdata_i = 32'hDEAD_BEEF; data_sel_i = 4'b1000;
        slave_lat = 2;
        run_access("store", 4);
        chk("store_drd_kept", data_rdata_o, 32'hC0DE_0080);
        idle_inputs();
        cycle();

        // Flush while a fetch waits; its late ack is dropped, next fetch reissues.
        slave_en = 0; bus_ack_i = 0;
        inst_ce_i = 1; inst_addr_i = 32'h20;
        cycle();
        cycle();
        flush_i = 1;
        cycle();
        flush_i = 0; inst_addr_i = 32'h24;
        cycle();
        chk("flush_req_held", bus_req_o, 1'b1);
        chk("flush_addr_held", bus_addr_o, 32'h20);
        cycle();
        bus_ack_i = 1; bus_rdata_i = 32'hFFFF_FFFF;
        cycle();
        bus_ack_i = 0;
        chk("flush_req_dropped", bus_req_o, 1'b0);
        chk("flush_inst_kept", inst_data_o, 32'hC0DE_0014);
        slave_en = 1; slave_cnt = 0; slave_mode = 0; slave_rdata = 32'h1111_2222; slave_lat = 0;
        run_access("after_flush", 2);
        chk("after_flush_inst", inst_data_o, 32'h1111_2222);
        idle_inputs();
        cycle();

        // Reset while a load is on the bus; a late ack is ignored.
        slave_en = 0; bus_ack_i = 0;
        data_ce_i = 1; data_we_i = 0; data_addr_i = 32'h200; data_sel_i = 4'hF;
        cycle();
        cycle();
        rst = 1;
        cycle();
        chk("rstmid_req", bus_req_o, 1'b0);
        chk("rstmid_we", bus_we_o, 1'b0);
        chk("rstmid_addr", bus_addr_o, 32'h0);
        chk("rstmid_sel", bus_sel_o, 4'h0);
        chk("rstmid_wdata", bus_wdata_o, 32'h0);
        chk("rstmid_inst", inst_data_o, 32'h0);
        rst = 0; idle_inputs();
        bus_ack_i = 1; bus_rdata_i = 32'h5555_AAAA;
        cycle();
        bus_ack_i = 0;
        cycle();
        chk("late_ack_req", bus_req_o, 1'b0);
        chk("late_ack_drd", data_rdata_o, 32'h0);

        // Back-to-back fetches with zero-wait slave.
        slave_en = 1; slave_cnt = 0; slave_mode = 2; slave_lat = 0;
        for (int a = 0; a < 3; a++) begin
            inst_ce_i = 1; inst_addr_i = a * 4;
            run_access("b2b_fetch", 2);
            chk("b2b_fetch_data", inst_data_o, 32'hC0DE_0000 | (a * 4));
        end
        idle_inputs();
        cycle();

        // Randomized pipeline-like traffic with occasional flushes.
        slave_mode = 1;
        for (int n = 0; n < 300; n++) begin
            bit done_ok;
            inst_ce_i    = ($urandom_range(0, 3) != 0);
            inst_addr_i  = $urandom & 32'hFFFF_FFFC;
            data_ce_i    = ($urandom_range(0, 1) == 1);
            data_we_i    = $urandom_range(0, 1);
            data_addr_i  = $urandom;
            data_sel_i   = $urandom;
            data_wdata_i = $urandom;
            slave_lat    = $urandom_range(0, 3);
            done_ok = 0;
            for (int c = 0; c < 60; c++) begin
                flush_i = ($urandom_range(0, 15) == 0);
                cycle();
                if (flush_i || !last_stall) begin
                    done_ok = 1;
                    break;
                end
            end
            flush_i = 0;
            if (!done_ok) chk("random_progress", done_ok, 1'b1);
        end
        idle_inputs();
        cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
